// File: rtl/piso_pkg.sv
// Shared definitions for the piso_stream serialiser: FSM state encoding and
// the bit-counter width helper.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width able to hold WIDTH (the parity-bit index when parity is on).
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// Frame bit counter for piso_stream: clears on load, steps on each consumed
// bit, and flags the terminal (final) bit of the frame.
module piso_bitcnt #(
  parameter int CNT_W    = 4,
  parameter int LAST_VAL = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic adv_i,
  input  logic active_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             term;

  assign term   = (cnt_q == CNT_W'(LAST_VAL));
  assign last_o = active_i & term;

  // Next count: load wins, otherwise advance and return to zero after the last bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = term ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in serial-out streamer with valid/ready handshakes on both sides.
// A captured word is emitted one bit per consumed beat, LSB or MSB first.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// after the data bits; out_last then marks the parity bit.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_W = WIDTH + 1;
`else
  localparam int FRAME_W = WIDTH;
`endif
  localparam int CNT_W = int'(cnt_width(WIDTH));

  state_e             state_q;
  state_e             state_d;
  logic [FRAME_W-1:0] shreg_q;
  logic [FRAME_W-1:0] shreg_d;
  logic [FRAME_W-1:0] load_word;
  logic [FRAME_W-1:0] shifted;
  logic               head_bit;
  logic               accept;
  logic               consume;
  logic               last;

  assign out_valid = (state_q == SHIFT);
  assign consume   = out_valid & out_ready;
  // Held low during reset so an upstream source cannot hand over a word then.
  assign in_ready  = rst_n & ((state_q == IDLE) | (consume & last));
  assign accept    = in_valid & in_ready;
  assign out_bit   = out_valid & head_bit;
  assign out_last  = last;

  // Frame image to load and its one-bit-advanced form, in emission order.
  always_comb begin
    load_word = '0;
    shifted   = '0;
    head_bit  = 1'b0;
    if (LSB_FIRST != 0) begin
`ifdef PISO_PARITY_EN
      load_word = {^in_data, in_data};
`else
      load_word = in_data;
`endif
      shifted  = {1'b0, shreg_q[FRAME_W-1:1]};
      head_bit = shreg_q[0];
    end else begin
`ifdef PISO_PARITY_EN
      load_word = {in_data, ^in_data};
`else
      load_word = in_data;
`endif
      shifted  = {shreg_q[FRAME_W-2:0], 1'b0};
      head_bit = shreg_q[FRAME_W-1];
    end
  end

  // Next-state and shift-register update: load on accept, shift on consume.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = load_word;
        end
      end
      SHIFT: begin
        if (consume) begin
          if (accept) begin
            shreg_d = load_word;
          end else if (last) begin
            state_d = IDLE;
            shreg_d = '0;
          end else begin
            shreg_d = shifted;
          end
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
      end
    endcase
  end

  // State and shift-register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      // NOTE: the datapath register is reset too, so a frame cut short by reset leaves no stale bits.
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  piso_bitcnt #(
    .CNT_W   (CNT_W),
    .LAST_VAL(FRAME_W - 1)
  ) u_bitcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .adv_i   (consume),
    .active_i(out_valid),
    .last_o  (last)
  );

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: one LSB-first and one MSB-first instance
// share the same stimulus; expected bit sequences are hand-computed.
module tb_piso_stream;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         l_ready, l_bit, l_valid, l_last;
  logic         m_ready, m_bit, m_valid, m_last;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(W), .LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l_ready), .out_bit(l_bit), .out_valid(l_valid),
    .out_ready(out_ready), .out_last(l_last)
  );

  piso_stream #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_ready), .out_bit(m_bit), .out_valid(m_valid),
    .out_ready(out_ready), .out_last(m_last)
  );

  // Word plus its emission order (first-emitted bit in [7]) for each bit order.
  typedef struct {
    logic [7:0] word;
    logic [7:0] lsb_seq;
    logic [7:0] msb_seq;
    logic       par;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Both instances present a valid bit.
  task automatic check_bit(input string tag, input logic eb_l, input logic eb_m,
                           input logic el, input logic er);
    #1;
    check({tag, " l_valid"}, 32'(l_valid), 32'd1);
    check({tag, " m_valid"}, 32'(m_valid), 32'd1);
    check({tag, " l_bit"},   32'(l_bit),   32'(eb_l));
    check({tag, " m_bit"},   32'(m_bit),   32'(eb_m));
    check({tag, " l_last"},  32'(l_last),  32'(el));
    check({tag, " m_last"},  32'(m_last),  32'(el));
    check({tag, " in_ready"}, 32'(l_ready), 32'(er));
    check({tag, " m_in_ready"}, 32'(m_ready), 32'(er));
  endtask

  // Nothing presented; all serial outputs must be zero.
  task automatic check_idle(input string tag, input logic er);
    #1;
    check({tag, " l_valid"}, 32'(l_valid), 32'd0);
    check({tag, " m_valid"}, 32'(m_valid), 32'd0);
    check({tag, " l_bit"},   32'(l_bit),   32'd0);
    check({tag, " m_bit"},   32'(m_bit),   32'd0);
    check({tag, " l_last"},  32'(l_last),  32'd0);
    check({tag, " m_last"},  32'(m_last),  32'd0);
    check({tag, " in_ready"}, 32'(l_ready), 32'(er));
    check({tag, " m_in_ready"}, 32'(m_ready), 32'(er));
  endtask

  // Offer one word in IDLE and let the capture edge pass.
  task automatic load_word(input logic [7:0] w, input logic keep_valid);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b1;
    #1;
    check("accept in_ready", 32'(l_ready), 32'd1);
    step();
    in_valid = keep_valid;
    in_data  = ~w;  // must be ignored while shifting
  endtask

  initial begin
    logic [15:0] b2b_l;
    logic [15:0] b2b_m;
    logic        eb_l, eb_m;
    string       tag;

    tbl[0] = '{word: 8'hA5, lsb_seq: 8'b10100101, msb_seq: 8'b10100101, par: 1'b0};
    tbl[1] = '{word: 8'h01, lsb_seq: 8'b10000000, msb_seq: 8'b00000001, par: 1'b1};
    tbl[2] = '{word: 8'h07, lsb_seq: 8'b11100000, msb_seq: 8'b00000111, par: 1'b1};
    tbl[3] = '{word: 8'h3C, lsb_seq: 8'b00111100, msb_seq: 8'b00111100, par: 1'b0};

    // Reset state.
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    check_idle("reset", 1'b0);
    step();
    rst_n = 1'b1;
    check_idle("post-reset", 1'b1);
    step();

    // Single frames from the table.
    for (int i = 0; i < 4; i++) begin
      load_word(tbl[i].word, 1'b0);
      for (int k = 0; k < FRAME; k++) begin
        eb_l = (k < W) ? tbl[i].lsb_seq[7-k] : tbl[i].par;
        eb_m = (k < W) ? tbl[i].msb_seq[7-k] : tbl[i].par;
        tag  = $sformatf("vec%0d bit%0d", i, k + 1);
        check_bit(tag, eb_l, eb_m, k == FRAME - 1, k == FRAME - 1);
        step();
      end
      check_idle($sformatf("vec%0d end", i), 1'b1);
    end

    // Back-to-back frames 0x0F then 0xF0 with in_valid held.
    b2b_l = {8'b11110000, 8'b00001111};
    b2b_m = {8'b00001111, 8'b11110000};
    load_word(8'h0F, 1'b1);
    in_data = 8'hF0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      int kk;
      int fr;
      kk = k % FRAME;
      fr = k / FRAME;
      if (fr == 1 && kk == 0) in_valid = 1'b0;
      eb_l = (kk < W) ? b2b_l[15 - (fr * 8 + kk)] : 1'b0;
      eb_m = (kk < W) ? b2b_m[15 - (fr * 8 + kk)] : 1'b0;
      check_bit($sformatf("b2b bit%0d", k + 1), eb_l, eb_m, kk == FRAME - 1, kk == FRAME - 1);
      step();
    end
    check_idle("b2b end", 1'b1);

    // Sink stall: out_ready low for 3 cycles while bit 2 of 0xC8 is shown.
    load_word(8'hC8, 1'b0);
    for (int k = 0; k < FRAME; k++) begin
      eb_l = (k < W) ? 8'b00010011 >> (7 - k) : 8'd1;
      eb_m = (k < W) ? 8'b11001000 >> (7 - k) : 8'd1;
      if (k == 1) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check_bit($sformatf("stall%0d", s), eb_l, eb_m, 1'b0, 1'b0);
          step();
        end
        out_ready = 1'b1;
      end
      check_bit($sformatf("stall bit%0d", k + 1), eb_l, eb_m, k == FRAME - 1, k == FRAME - 1);
      step();
    end
    check_idle("stall end", 1'b1);

    // Reset pulsed after bit 4 of 0x3C has been consumed.
    load_word(8'h3C, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_bit($sformatf("mid bit%0d", k + 1), tbl[3].lsb_seq[7-k], tbl[3].msb_seq[7-k],
                1'b0, 1'b0);
      step();
    end
    rst_n = 1'b0;
    check_idle("mid reset", 1'b0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_idle($sformatf("after reset%0d", c), 1'b1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
